// File: rtl/frame_ram_pkg.sv
// Shared widths, arbiter state encoding and the video FIFO entry type
// used by frame_ram_arbiter and frame_ram_wfifo.
package frame_ram_pkg;

  localparam int ADR_W  = 15;
  localparam int DATA_W = 16;
  localparam int RAM_AW = ADR_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_VWR   = 3'd1,
    ST_HRD   = 3'd2,
    ST_HWAIT = 3'd3,
    ST_HOLD  = 3'd4,
    ST_HWR   = 3'd5
  } arb_state_t;

  typedef struct packed {
    logic              bank;
    logic [ADR_W-1:0]  adr;
    logic [DATA_W-1:0] data;
  } wfifo_entry_t;

endpackage

// File: rtl/frame_ram_wfifo.sv
// Video write FIFO: registered pointers, simultaneous push/pop accepted even when full.
module frame_ram_wfifo
  import frame_ram_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         Sys_clk,
  input  logic         resetx,
  input  logic         push,
  input  logic         pop,
  input  wfifo_entry_t din,
  output wfifo_entry_t dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wfifo_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge Sys_clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge Sys_clk or negedge resetx) begin
    if (!resetx) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/frame_ram_arbiter.sv
// Arbitrates one frame RAM between buffered video writes and host accesses,
// with double-banked frames. Optional macro HOST_WR_EN adds the host write path.
module frame_ram_arbiter
  import frame_ram_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOST_STARVE = 8
) (
  input  logic              Sys_clk,
  input  logic              resetx,
  input  logic              vid_wr_req,
  input  logic [ADR_W-1:0]  vid_wr_adr,
  input  logic [DATA_W-1:0] vid_wr_data,
  input  logic              frame_done,
  input  logic              host_csx,
  input  logic              host_rdx,
  input  logic              host_wrx,
  input  logic [ADR_W-1:0]  host_adr,
`ifdef HOST_WR_EN
  input  logic [DATA_W-1:0] host_wdata,
`endif
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_waitx,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  output logic              ram_rden,
  input  logic [DATA_W-1:0] ram_q,
  output logic              irq0,
  output logic              irq1,
  output logic              fifo_ovf,
  output arb_state_t        dbg_state,
  output logic              dbg_rd_bank
);

  localparam int SW = $clog2(HOST_STARVE + 1);

  arb_state_t     state;
  wfifo_entry_t   head;
  logic           fifo_full, fifo_empty, pop;
  logic           rd_pend, wr_pend, host_pend, starved, go_vwr, go_host, fire;
  logic [SW-1:0]  starve_cnt;
  logic           wr_bank, rd_bank, irq_bank, irq_pend, irq_left;

  // Host protocol: a request is held (csx low plus rdx/wrx low) until host_waitx
  // returns high; the host then releases its strobe, which ends the access.
  assign rd_pend = !host_csx && !host_rdx;
`ifdef HOST_WR_EN
  assign wr_pend = !host_csx && !host_wrx;
`else
  logic unused_host_wrx;
  assign unused_host_wrx = host_wrx;
  assign wr_pend = 1'b0;
`endif
  assign host_pend = rd_pend || wr_pend;
  assign starved   = (starve_cnt >= SW'(HOST_STARVE));
  assign go_host   = (state == ST_IDLE) && host_pend && (fifo_empty || starved);
  assign go_vwr    = (state == ST_IDLE) && !fifo_empty && !(host_pend && starved);
  assign pop       = go_vwr;
  assign fire      = irq_pend && fifo_empty && (state != ST_VWR);
  assign dbg_state   = state;
  assign dbg_rd_bank = rd_bank;

  frame_ram_wfifo #(.DEPTH(FIFO_DEPTH)) u_wfifo (
    .Sys_clk (Sys_clk),
    .resetx  (resetx),
    .push    (vid_wr_req),
    .pop     (pop),
    .din     ('{bank: wr_bank, adr: vid_wr_adr, data: vid_wr_data}),
    .dout    (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge Sys_clk or negedge resetx) begin
    if (!resetx) begin
      state      <= ST_IDLE;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_wren   <= 1'b0;
      ram_rden   <= 1'b0;
      host_rdata <= '0;
      host_waitx <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          host_waitx <= ~host_pend;
          if (go_host && rd_pend) begin
            state    <= ST_HRD;
            ram_rden <= 1'b1;
            ram_addr <= {rd_bank, host_adr};
`ifdef HOST_WR_EN
          end else if (go_host) begin
            state     <= ST_HWR;
            ram_wren  <= 1'b1;
            ram_addr  <= {~rd_bank, host_adr};
            ram_wdata <= host_wdata;
`endif
          end else if (go_vwr) begin
            state     <= ST_VWR;
            ram_wren  <= 1'b1;
            ram_addr  <= {head.bank, head.adr};
            ram_wdata <= head.data;
          end
        end
        ST_VWR: begin
          ram_wren   <= 1'b0;
          host_waitx <= ~host_pend;
          state      <= ST_IDLE;
        end
        ST_HRD: begin
          ram_rden   <= 1'b0;
          host_waitx <= 1'b0;
          state      <= ST_HWAIT;
        end
        ST_HWAIT: begin
          host_rdata <= ram_q;
          host_waitx <= 1'b0;
          state      <= ST_HOLD;
        end
`ifdef HOST_WR_EN
        ST_HWR: begin
          ram_wren   <= 1'b0;
          host_waitx <= 1'b0;
          state      <= ST_HOLD;
        end
`endif
        ST_HOLD: begin
          host_waitx <= 1'b1;
          if (!host_pend) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Starvation only accrues while the host waits behind video traffic.
  always_ff @(posedge Sys_clk or negedge resetx) begin
    if (!resetx) begin
      starve_cnt <= '0;
    end else if (go_host || !host_pend) begin
      starve_cnt <= '0;
    end else if (((state == ST_IDLE) || (state == ST_VWR)) && !starved) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  always_ff @(posedge Sys_clk or negedge resetx) begin
    if (!resetx) begin
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b1;
      irq_bank <= 1'b0;
      irq_pend <= 1'b0;
      irq_left <= 1'b0;
      irq0     <= 1'b0;
      irq1     <= 1'b0;
      fifo_ovf <= 1'b0;
    end else begin
      if (vid_wr_req && fifo_full && !pop) fifo_ovf <= 1'b1;
      // A later frame_done overwrites the bank of a not-yet-issued irq.
      if (frame_done) begin
        wr_bank  <= ~wr_bank;
        irq_bank <= wr_bank;
        irq_pend <= 1'b1;
      end else if (fire) begin
        irq_pend <= 1'b0;
      end
      if (fire) begin
        rd_bank  <= irq_bank;
        irq0     <= ~irq_bank;
        irq1     <= irq_bank;
        irq_left <= 1'b1;
      end else if (irq_left) begin
        irq_left <= 1'b0;
      end else begin
        irq0 <= 1'b0;
        irq1 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Directed bench for frame_ram_arbiter: RAM model, write scoreboard and
// hand-computed expectations for write, read, overflow, starvation and bank handoff.
module tb_frame_ram_arbiter;
  import frame_ram_pkg::*;

  localparam int FIFO_DEPTH  = 4;
  localparam int HOST_STARVE = 8;

  logic        Sys_clk     = 1'b0;
  logic        resetx      = 1'b0;
  logic        vid_wr_req  = 1'b0;
  logic [14:0] vid_wr_adr  = '0;
  logic [15:0] vid_wr_data = '0;
  logic        frame_done  = 1'b0;
  logic        host_csx    = 1'b1;
  logic        host_rdx    = 1'b1;
  logic        host_wrx    = 1'b1;
  logic [14:0] host_adr    = '0;
  logic [15:0] host_rdata;
  logic        host_waitx;
  logic [15:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_wren;
  logic        ram_rden;
  logic [15:0] ram_q = '0;
  logic        irq0, irq1, fifo_ovf;
  arb_state_t  dbg_state;
  logic        dbg_rd_bank;

  int total = 0;
  int bad   = 0;

  frame_ram_arbiter #(.FIFO_DEPTH(FIFO_DEPTH), .HOST_STARVE(HOST_STARVE)) dut (
    .Sys_clk     (Sys_clk),
    .resetx      (resetx),
    .vid_wr_req  (vid_wr_req),
    .vid_wr_adr  (vid_wr_adr),
    .vid_wr_data (vid_wr_data),
    .frame_done  (frame_done),
    .host_csx    (host_csx),
    .host_rdx    (host_rdx),
    .host_wrx    (host_wrx),
    .host_adr    (host_adr),
    .host_rdata  (host_rdata),
    .host_waitx  (host_waitx),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_wren    (ram_wren),
    .ram_rden    (ram_rden),
    .ram_q       (ram_q),
    .irq0        (irq0),
    .irq1        (irq1),
    .fifo_ovf    (fifo_ovf),
    .dbg_state   (dbg_state),
    .dbg_rd_bank (dbg_rd_bank)
  );

  // Clock and watchdog
  always #5 Sys_clk = ~Sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // RAM model with 1-cycle read latency
  logic [15:0] mem [0:65535];
  always @(posedge Sys_clk) begin
    if (ram_wren) mem[ram_addr] <= ram_wdata;
    if (ram_rden) ram_q <= mem[ram_addr];
  end

  // Scoreboard: every RAM write must match the oldest expected {addr, data}
  logic [31:0] exp_q[$];
  int          wr_seen   = 0;
  logic        sb_en     = 1'b1;
  logic        prev_wren = 1'b0;
  always @(negedge Sys_clk) begin
    if (resetx && sb_en) begin
      if (ram_wren || ram_rden) check("rw_excl", 32'(ram_wren & ram_rden), 0);
      if (ram_wren) begin
        wr_seen++;
        check("wren_1cyc", 32'(prev_wren), 0);
        check("wr_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("wr_word", {ram_addr, ram_wdata}, exp_q.pop_front());
      end
    end
    prev_wren = ram_wren;
  end

  // Driver tasks (all start and end just after a falling edge)
  task automatic tick();
    @(posedge Sys_clk);
    @(negedge Sys_clk);
  endtask

  task automatic do_reset();
    resetx = 1'b0;
    vid_wr_req = 1'b0; frame_done = 1'b0;
    host_csx = 1'b1; host_rdx = 1'b1; host_wrx = 1'b1;
    exp_q.delete();
    repeat (2) tick();
    resetx = 1'b1;
    tick();
  endtask

  task automatic vid_push(input logic [14:0] adr, input logic [15:0] data, input logic bank, input logic fd);
    vid_wr_req = 1'b1; vid_wr_adr = adr; vid_wr_data = data; frame_done = fd;
    exp_q.push_back({bank, adr, data});
    tick();
    vid_wr_req = 1'b0; frame_done = 1'b0;
  endtask

  task automatic host_read(input logic [14:0] adr);
    host_adr = adr; host_csx = 1'b0; host_rdx = 1'b0;
  endtask

  task automatic host_release();
    host_csx = 1'b1; host_rdx = 1'b1; host_wrx = 1'b1;
  endtask

  task automatic wait_state(input string tag, input arb_state_t s, input int limit);
    int n = 0;
    while (dbg_state !== s && n < limit) begin
      tick();
      n++;
    end
    check(tag, dbg_state, s);
  endtask

  initial begin
    int k;
    int low_cnt;
    int rden_cnt;
    int w0;
    logic [15:0] rd_addr;
    mem[16'h8005] = 16'h1234;
    @(negedge Sys_clk);

    // Reset state
    do_reset();
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_wren", ram_wren, 0);
    check("rst_rden", ram_rden, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_wdata", ram_wdata, 0);
    check("rst_waitx", host_waitx, 1);
    check("rst_rdata", host_rdata, 0);
    check("rst_irq", {irq1, irq0}, 0);
    check("rst_ovf", fifo_ovf, 0);
    check("rst_rd_bank", dbg_rd_bank, 1);

    // Single video write: RAM write two cycles after the strobe
    vid_push(15'h0010, 16'hF800, 1'b0, 1'b0);
    check("vwr_early", ram_wren, 0);
    tick();
    check("vwr_wren", ram_wren, 1);
    check("vwr_addr", ram_addr, 16'h0010);
    check("vwr_data", ram_wdata, 16'hF800);
    tick();
    check("vwr_wren_off", ram_wren, 0);

    // Host read from bank 1
    host_read(15'h0005);
    low_cnt = 0; rden_cnt = 0; rd_addr = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (!host_waitx) low_cnt++;
      if (ram_rden) begin
        rden_cnt++;
        rd_addr = ram_addr;
      end
    end
    check("hrd_addr", rd_addr, 16'h8005);
    check("hrd_rden_cycles", rden_cnt, 1);
    check("hrd_waitx_low", low_cnt, 3);
    check("hrd_rdata", host_rdata, 16'h1234);
    check("hrd_hold", dbg_state, ST_HOLD);
    host_release();
    tick();
    check("hrd_release", dbg_state, ST_IDLE);

    // Host writes are ignored in the default build
    w0 = wr_seen;
    host_adr = 15'h0007; host_csx = 1'b0; host_wrx = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hwr_waitx", host_waitx, 1);
    end
    check("hwr_state", dbg_state, ST_IDLE);
    check("hwr_no_access", wr_seen - w0, 0);
    host_release();

    // Overflow: FIFO fills while a host read holds the RAM
    do_reset();
    host_read(15'h0005);
    wait_state("ovf_hold", ST_HOLD, 10);
    for (int i = 0; i < 5; i++) begin
      vid_wr_req = 1'b1;
      vid_wr_adr = 15'(16'h0100 + i);
      vid_wr_data = 16'(16'hA000 + i);
      if (i < FIFO_DEPTH) exp_q.push_back({1'b0, vid_wr_adr, vid_wr_data});
      if (i == FIFO_DEPTH) check("ovf_before_drop", fifo_ovf, 0);
      tick();
    end
    vid_wr_req = 1'b0;
    check("ovf_set", fifo_ovf, 1);
    w0 = wr_seen;
    host_release();
    repeat (14) tick();
    check("ovf_stored", wr_seen - w0, FIFO_DEPTH);
    check("ovf_drained", exp_q.size(), 0);
    check("ovf_sticky", fifo_ovf, 1);

    // Starvation: continuous video writes must not lock out the host
    do_reset();
    sb_en = 1'b0;
    vid_wr_req = 1'b1; vid_wr_adr = 15'h0200; vid_wr_data = 16'h5555;
    repeat (3) tick();
    check("starve_pre_idle", dbg_state, ST_IDLE);
    host_read(15'h0005);
    tick();
    k = 0;
    while (dbg_state !== ST_HRD && k < 20) begin
      tick();
      k++;
    end
    check("starve_wait", k, HOST_STARVE);
    check("starve_hrd", dbg_state, ST_HRD);
    vid_wr_req = 1'b0;
    host_release();
    do_reset();
    sb_en = 1'b1;

    // Bank handoff: frame_done with two entries queued
    vid_push(15'h0020, 16'h1111, 1'b0, 1'b0);
    vid_push(15'h0021, 16'h2222, 1'b0, 1'b1);
    k = 0;
    while (!irq0 && k < 12) begin
      tick();
      k++;
    end
    check("bank_irq_delay", k, 4);
    check("bank_irq0_1", irq0, 1);
    check("bank_drained", exp_q.size(), 0);
    tick();
    check("bank_irq0_2", irq0, 1);
    tick();
    check("bank_irq0_end", irq0, 0);
    check("bank_irq1", irq1, 0);
    check("bank_rd_bank", dbg_rd_bank, 0);
    vid_push(15'h0030, 16'h3333, 1'b1, 1'b0);
    repeat (4) tick();
    check("bank_next_push", exp_q.size(), 0);

    // Asynchronous reset in the middle of HOLD
    do_reset();
    host_read(15'h0005);
    wait_state("rst_hold_reach", ST_HOLD, 10);
    check("rst_hold_rdata_pre", host_rdata, 16'h1234);
    resetx = 1'b0;
    #1;
    check("rst_hold_waitx", host_waitx, 1);
    check("rst_hold_rdata", host_rdata, 0);
    check("rst_hold_state", dbg_state, ST_IDLE);
    host_release();
    tick();
    resetx = 1'b1;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_ram_arbiter.md
FRAME_RAM_ARBITER -- requirements
Module: frame_ram_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: video write FIFO entries, power of two, 2..16.
REQ-002 SHALL have parameter HOST_STARVE, default 8: number of cycles a pending host request waits before it overrides video priority.
REQ-003 SHALL have port Sys_clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 SHALL have port resetx, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port vid_wr_req, input, 1 bit: one-cycle pixel write strobe, already in the Sys_clk domain.
REQ-006 SHALL have ports vid_wr_adr (input, 15 bits) and vid_wr_data (input, 16 bits): pixel word address within a bank, and the RGB565 pixel.
REQ-007 SHALL have port frame_done, input, 1 bit: one-cycle pulse marking the end of the captured field.
REQ-008 SHALL have ports host_csx, host_rdx and host_wrx, inputs, 1 bit each: active-low host strobes, already synchronized.
REQ-009 SHALL have port host_adr (input, 15 bits) and port host_rdata (output, 16 bits).
REQ-010 SHALL have port host_waitx, output, 1 bit: active-low host wait.
REQ-011 SHALL have port ram_addr (output, 16 bits), port ram_wdata (output, 16 bits), ports ram_wren and ram_rden (outputs, 1 bit each), and port ram_q (input, 16 bits); the RAM read latency is 1 cycle.
REQ-012 SHALL have ports irq0 and irq1, outputs, 1 bit each: bank-0 and bank-1 frame-ready pulses.
REQ-013 SHALL have port fifo_ovf, output, 1 bit: sticky flag for a dropped video write.

Function
REQ-014 SHALL push {wr_bank, vid_wr_adr, vid_wr_data} into the FIFO on vid_wr_req; the bank bit is captured at push time.
REQ-015 SHALL drop a vid_wr_req that arrives while the FIFO is full with no pop in the same cycle, and SHALL set fifo_ovf; a push and a pop together on a full FIFO SHALL be accepted.
REQ-016 SHALL implement states IDLE, VWR, HRD, HWAIT, HOLD (plus HWR under the macro).
- IDLE -> VWR when the FIFO is non-empty and the starve counter is below HOST_STARVE.
- IDLE -> HRD when a host read is pending (host_csx=0, host_rdx=0), and either the FIFO is empty or the starve counter has reached HOST_STARVE.
REQ-017 SHALL, in VWR, assert ram_wren for exactly 1 cycle with the head entry, pop it, and return to IDLE.
REQ-018 SHALL, in HRD, assert ram_rden with ram_addr={rd_bank, host_adr}, then move to HWAIT.
REQ-019 SHALL, in HWAIT, latch ram_q into host_rdata, then move to HOLD.
REQ-020 SHALL stay in HOLD until host_rdx=1 or host_csx=1, then return to IDLE.
REQ-021 SHALL drive host_waitx=0 from the first cycle a host read is pending until the cycle after host_rdata is latched; otherwise host_waitx=1.
REQ-022 SHALL count cycles in which a host request is pending but not served (saturating at HOST_STARVE), and SHALL clear the count on entry to HRD.
REQ-023 SHALL toggle wr_bank on frame_done, after any push in the same cycle, and SHALL set a pending-irq flag recording the completed bank.
REQ-024 SHALL, on the first cycle with the irq flag pending, the FIFO empty and the state not VWR:
- copy the completed bank into rd_bank;
- pulse irq0 (bank 0) or irq1 (bank 1) for exactly 2 cycles;
- clear the pending flag.
REQ-025 SHALL, on a second frame_done while an irq is still pending, overwrite the recorded bank; one irq is issued, for the latest bank.
REQ-026 SHALL keep ram_wren and ram_rden mutually exclusive, and SHALL never assert either for more than 1 cycle per access.

Reset
REQ-027 SHALL, on resetx=0 at any time, immediately clear the state to IDLE and set:
- FIFO empty, fifo_ovf=0, starve counter=0, irq flag clear;
- wr_bank=0, rd_bank=1;
- host_rdata=0, host_waitx=1, irq0=irq1=0, ram_wren=ram_rden=0, ram_addr=0, ram_wdata=0.

Configuration
REQ-028 SHALL, with HOST_WR_EN defined, serve a pending host write (host_csx=0, host_wrx=0) like a read:
- one HWR cycle with ram_wren=1 and ram_addr={~rd_bank, host_adr};
- then HOLD until the strobe deasserts.
REQ-029 SHALL, without HOST_WR_EN, ignore host writes: no RAM access and host_waitx=1.

Structure
REQ-030 SHALL place the state enum, address/data width constants and the FIFO entry type in the shared package frame_ram_pkg.
REQ-031 SHALL implement the video FIFO as the sub-module frame_ram_wfifo (push/pop/full/empty).

Verification
REQ-032 SHALL check a single video write: vid_wr_req with adr 0x0010, data 0xF800, bank 0 -> ram_wren=1 two cycles later, ram_addr=0x0010, ram_wdata=0xF800.
REQ-033 SHALL check overflow: 5 back-to-back writes while a host read holds the RAM -> 4 writes stored and fifo_ovf=1.
REQ-034 SHALL check a host read: host_rdx low at adr 0x0005, rd_bank=1, ram_q=0x1234 -> ram_addr=0x8005, host_rdata=0x1234, and host_waitx low for 3 cycles.
REQ-035 SHALL check starvation: continuous video writes plus a host read -> HRD entered no later than 8 cycles after the request.
REQ-036 SHALL check bank handoff: frame_done with 2 FIFO entries -> irq0 pulses for 2 cycles after the FIFO drains, rd_bank=0, and the next push uses bank 1.
REQ-037 SHALL check reset mid-HOLD: resetx low -> host_waitx=1, host_rdata=0 and the state is IDLE in the same cycle.
